// File: rtl/l2norm_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one L2-norm engine between N_REQ
// AXI-Stream requesters; tags each engine result with the index of its source.
module l2norm_stream_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64,
  parameter int RES_W  = 32,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  input  logic [N_REQ-1:0]        req_en,
  output logic [DATA_W-1:0]       eng_in_tdata,
  output logic                    eng_in_tvalid,
  output logic                    eng_in_tlast,
  input  logic                    eng_in_tready,
  input  logic [RES_W-1:0]        eng_out_tdata,
  input  logic                    eng_out_tvalid,
  output logic                    eng_out_tready,
  output logic [RES_W-1:0]        m_tdata,
  output logic [ID_W-1:0]         m_tid,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    busy,
  output logic [31:0]             pkt_count
);

  // state    | meaning
  // ST_IDLE  | no owner; pick next eligible requester at or after rr_q
  // ST_GRANT | requester g_q owns the engine input until its tlast handshake
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   g_q, rr_q, tag_q;
  logic              busy_q;
  logic [31:0]       pkt_count_q;

  logic [DATA_W-1:0] beat [N_REQ];
  logic [N_REQ-1:0]  elig;
  logic [ID_W-1:0]   pick_d, g_inc_d;
  logic              any_elig, grant, block, last_hs;

  for (genvar i = 0; i < N_REQ; i++) begin : g_beat
    assign beat[i] = s_tdata[i*DATA_W +: DATA_W];
  end

  // Walk offsets from high to low so the smallest offset from rr_q wins.
  always_comb begin : pick
    logic [ID_W:0] cand;
    cand     = '0;
    pick_d   = rr_q;
    any_elig = 1'b0;
    elig     = s_tvalid & req_en;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (elig[cand[ID_W-1:0]]) begin
        pick_d   = cand[ID_W-1:0];
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    g_inc_d = g_q + 1'b1;
    if (g_q == ID_W'(N_REQ - 1)) g_inc_d = '0;
  end

  // A last beat may not enter while the engine still holds an unconsumed result.
  always_comb begin
    grant         = (state_q == ST_GRANT);
    eng_in_tdata  = beat[g_q];
    eng_in_tlast  = s_tlast[g_q];
    block         = s_tlast[g_q] && eng_out_tvalid && !m_tready;
    eng_in_tvalid = grant && s_tvalid[g_q] && !block;
    s_tready      = '0;
    s_tready[g_q] = grant && eng_in_tready && !block;
    last_hs       = eng_in_tvalid && eng_in_tready && s_tlast[g_q];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      rr_q        <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_q + 32'(m_tvalid && m_tready);
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            g_q     <= pick_d;
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (last_hs) begin
            tag_q   <= g_q;
            rr_q    <= g_inc_d;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m_tdata        = eng_out_tdata;
  assign m_tvalid       = eng_out_tvalid;
  assign m_tlast        = eng_out_tvalid;
  assign eng_out_tready = m_tready;
  assign m_tid          = tag_q;
  assign busy           = busy_q;
  assign pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_l2norm_stream_arbiter.sv
// Bench for l2norm_stream_arbiter: behavioural L2-norm engine, per-requester beat
// queues, and a result scoreboard filled by the directed steps.
module tb_l2norm_stream_arbiter;

  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [N*64-1:0] s_tdata;
  logic [N-1:0]  s_tvalid, s_tlast, s_tready, req_en;
  logic [63:0]   eng_in_tdata;
  logic          eng_in_tvalid, eng_in_tlast, eng_in_tready;
  logic [31:0]   eng_out_tdata;
  logic          eng_out_tvalid, eng_out_tready;
  logic [31:0]   m_tdata;
  logic [1:0]    m_tid;
  logic          m_tvalid, m_tlast, m_tready;
  logic          busy;
  logic [31:0]   pkt_count;

  l2norm_stream_arbiter #(.N_REQ(N), .DATA_W(64), .RES_W(32)) dut (
    .clock(clock), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .req_en(req_en),
    .eng_in_tdata(eng_in_tdata), .eng_in_tvalid(eng_in_tvalid),
    .eng_in_tlast(eng_in_tlast), .eng_in_tready(eng_in_tready),
    .eng_out_tdata(eng_out_tdata), .eng_out_tvalid(eng_out_tvalid),
    .eng_out_tready(eng_out_tready),
    .m_tdata(m_tdata), .m_tid(m_tid), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [63:0] d; logic l; } beat_t;
  typedef struct packed { logic [1:0] id; logic [31:0] d; } exp_t;

  beat_t rq [N][$];
  exp_t  exp_q [$];
  int    n_vec = 0;
  int    n_err = 0;
  logic [N-1:0] hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sumsq(input logic [63:0] d);
    int s = 0;
    for (int k = 0; k < 8; k++) begin
      logic signed [7:0] e;
      int ei;
      e  = d[k*8 +: 8];
      ei = int'(e);
      s += ei * ei;
    end
    return 32'(s);
  endfunction

  // Behavioural engine: accumulate per packet, single result register.
  logic [31:0] acc_q;
  always @(posedge clock) begin
    if (!reset) begin
      acc_q          <= '0;
      eng_out_tvalid <= 1'b0;
      eng_out_tdata  <= '0;
    end else if (eng_in_tvalid && eng_in_tready) begin
      if (eng_in_tlast) begin
        eng_out_tdata  <= acc_q + sumsq(eng_in_tdata);
        eng_out_tvalid <= 1'b1;
        acc_q          <= '0;
      end else begin
        acc_q <= acc_q + sumsq(eng_in_tdata);
      end
    end else if (eng_out_tvalid && eng_out_tready) begin
      eng_out_tvalid <= 1'b0;
    end
  end

  // Requester driver: sample handshakes at negedge, advance queues after the edge.
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    forever begin
      @(negedge clock);
      hs = s_tvalid & s_tready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          s_tvalid[i]         = 1'b1;
          s_tdata[i*64 +: 64] = rq[i][0].d;
          s_tlast[i]          = rq[i][0].l;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Result monitor and overwrite guard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", m_tvalid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("m_tid", m_tid, e.id);
          chk("m_tdata", m_tdata, e.d);
          chk("m_tlast", m_tlast, 1'b1);
        end
      end
      if (reset && eng_in_tvalid && eng_in_tready && eng_in_tlast && eng_out_tvalid)
        chk("no_overwrite", m_tready, 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input int i, input int nb, input logic [7:0] b);
    for (int k = 0; k < nb; k++) rq[i].push_back('{d: {8{b}}, l: (k == nb - 1)});
  endtask

  task automatic push_exp(input logic [1:0] id, input int nb, input logic [7:0] b);
    int bs;
    bs = int'(signed'(b));
    exp_q.push_back('{id: id, d: 32'(nb * 8 * bs * bs)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && all_empty())) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk({"drain_", tag}, 64'(exp_q.size()), 64'd0);
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    m_tready      = 1'b1;
    req_en        = '1;
    eng_in_tready = 1'b1;
    @(posedge clock);
    #2;
    do_reset();

    // reset state
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_tready", s_tready, 4'b0);
    chk("rst_eng_in_tvalid", eng_in_tvalid, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_m_tid", m_tid, 2'd0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);

    // single requester, 2-beat packet
    @(posedge clock);
    #2;
    push_pkt(0, 2, 8'h02);
    push_exp(2'd0, 2, 8'h02);
    @(posedge clock);
    #2;
    @(negedge clock);
    chk("t1_idle_bubble_ready", s_tready[0], 1'b0);
    chk("t1_idle_bubble_busy", busy, 1'b0);
    @(negedge clock);
    chk("t1_grant_ready", s_tready[0], 1'b1);
    chk("t1_grant_busy", busy, 1'b1);
    chk("t1_eng_in_tdata", eng_in_tdata, 64'h0202_0202_0202_0202);
    wait_drain("t1", 50);
    @(negedge clock);
    chk("t1_pkt_count", pkt_count, 32'd1);

    // four requesters, 1-beat packets, round robin 0,1,2,3,0
    do_reset();
    push_pkt(0, 1, 8'h01);
    push_pkt(0, 1, 8'h01);
    push_pkt(1, 1, 8'h01);
    push_pkt(2, 1, 8'h01);
    push_pkt(3, 1, 8'h01);
    push_exp(2'd0, 1, 8'h01);
    push_exp(2'd1, 1, 8'h01);
    push_exp(2'd2, 1, 8'h01);
    push_exp(2'd3, 1, 8'h01);
    push_exp(2'd0, 1, 8'h01);
    wait_drain("t2", 100);
    @(negedge clock);
    chk("t2_pkt_count", pkt_count, 32'd5);

    // req_en[1]=0: order 0,2,0,2
    do_reset();
    req_en = 4'b1101;
    push_pkt(0, 1, 8'h01);
    push_pkt(0, 1, 8'h01);
    push_pkt(1, 1, 8'h02);
    push_pkt(2, 1, 8'h03);
    push_pkt(2, 1, 8'h03);
    push_exp(2'd0, 1, 8'h01);
    push_exp(2'd2, 1, 8'h03);
    push_exp(2'd0, 1, 8'h01);
    push_exp(2'd2, 1, 8'h03);
    while (exp_q.size() != 0 && n_vec < 100000) begin
      @(negedge clock);
      #1;
      if (!busy && rq[0].size() == 0 && rq[2].size() == 0 && exp_q.size() == 0) break;
    end
    @(posedge clock);
    #2;
    chk("t3_req1_skipped", 64'(rq[1].size()), 64'd1);
    // dropping req_en[0] mid-packet lets the packet finish
    push_pkt(0, 3, 8'h01);
    push_exp(2'd0, 3, 8'h01);
    repeat (3) begin
      @(posedge clock);
      #2;
    end
    req_en[0] = 1'b0;
    @(negedge clock);
    chk("t3_midpkt_busy", busy, 1'b1);
    wait_drain("t3a", 50);
    push_exp(2'd1, 1, 8'h02);
    req_en = '1;
    wait_drain("t3b", 50);

    // result stall: tlast beat from requester 2 held off until m_tready
    do_reset();
    m_tready = 1'b0;
    push_pkt(0, 1, 8'h01);
    push_pkt(2, 1, 8'h02);
    push_exp(2'd0, 1, 8'h01);
    push_exp(2'd2, 1, 8'h02);
    begin
      int n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!m_tvalid && n < 20);
    end
    chk("t4_first_result", m_tvalid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      chk("t4_hold_data", m_tdata, 32'd8);
      chk("t4_hold_tid", m_tid, 2'd0);
      chk("t4_s_tready2", s_tready[2], 1'b0);
      chk("t4_eng_in_tvalid", eng_in_tvalid, 1'b0);
    end
    chk("t4_stalled_busy", busy, 1'b1);
    @(posedge clock);
    #2;
    m_tready = 1'b1;
    wait_drain("t4", 50);
    @(negedge clock);
    chk("t4_pkt_count", pkt_count, 32'd2);

    // reset on the second beat of a 3-beat packet
    @(posedge clock);
    #2;
    push_pkt(1, 3, 8'h01);
    begin
      int n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!(s_tvalid[1] && s_tready[1]) && n < 20);
      chk("t5_first_beat", s_tready[1], 1'b1);
    end
    @(posedge clock);
    #2;
    reset = 1'b0;
    rq[1].delete();
    @(posedge clock);
    @(negedge clock);
    chk("t5_busy", busy, 1'b0);
    chk("t5_s_tready", s_tready, 4'b0);
    chk("t5_pkt_count", pkt_count, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    push_pkt(3, 2, 8'h03);
    push_exp(2'd3, 2, 8'h03);
    wait_drain("t5", 50);

    // pkt_count wrap
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(posedge clock);
    #2;
    release dut.pkt_count_q;
    @(negedge clock);
    chk("t6_preload", pkt_count, 32'hFFFF_FFFF);
    @(posedge clock);
    #2;
    push_pkt(0, 1, 8'h01);
    push_exp(2'd0, 1, 8'h01);
    wait_drain("t6", 50);
    @(negedge clock);
    chk("t6_wrap", pkt_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
